hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline control block for the 16-bit 5-stage processor. It drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- It consumes the register fields and control vector that the decode stage publishes (rsD/rtD, rsE/rtE, MemReadE, FloatingE, StopE) and generates the EX-stage operand forwarding selects.
- It owns two sequential mechanisms: a multi-cycle floating-point busy timer and a sticky halt state.

Parameters:
- REG_WIDTH, 4, register-address width.
- FP_LATENCY, 4, total EX cycles a Floating instruction occupies (legal range 1..15).
- R0_IS_ZERO, 1, when 1, never forward for destination register 0.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rsD  input  REG_WIDTH  ID source register 1
- rtD  input  REG_WIDTH  ID source register 2
- rsE  input  REG_WIDTH  EX source register 1
- rtE  input  REG_WIDTH  EX source register 2 / load destination
- MemReadE  input  1  EX instruction is a load
- BranchE  input  1  EX instruction is a branch
- branch_taken_i  input  1  EX branch condition true
- JumpD  input  1  ID instruction is a jump (target already sent to IF)
- FloatingE  input  1  EX instruction is floating-point
- StopE  input  1  EX instruction is STOP
- RegWriteM  input  1  MEM stage writes the register file
- WriteRegM  input  REG_WIDTH  MEM destination register
- RegWriteW  input  1  WB stage writes the register file
- WriteRegW  input  REG_WIDTH  WB destination register
- stall_IF_o  output  1  hold PC
- stall_IF_ID_o  output  1  hold IF/ID
- flush_IF_ID_o  output  1  clear IF/ID
- stall_ID_EX_o  output  1  hold ID/EX
- flush_ID_EX_o  output  1  bubble ID/EX
- flush_EX_MEM_o  output  1  bubble EX/MEM
- forwardAE_o  output  2  EX operand A select
- forwardBE_o  output  2  EX operand B select
- halt_o  output  1  processor halted

Behaviour:
- Reset: state=IDLE, fp_cnt=0, halt_o=0. While rst=1, every stall/flush output and both forward selects are 0.
- Forwarding (combinational):
  - forwardAE_o=2'b10 if RegWriteM and WriteRegM==rsE (and WriteRegM!=0 when R0_IS_ZERO).
  - Otherwise 2'b01 on the same test against RegWriteW/WriteRegW.
  - Otherwise 2'b00.
  - forwardBE_o follows the same rules using rtE. MEM has priority over WB.
- Load-use: lwstall = MemReadE and (rtE==rsD or rtE==rtD). Response: stall_IF_o=1, stall_IF_ID_o=1, flush_ID_EX_o=1. The penalty is exactly 1 bubble.
- Branch taken: BranchE and branch_taken_i. Response: flush_IF_ID_o=1, flush_ID_EX_o=1 for 1 cycle; the load-use stall is suppressed that cycle.
- Jump: JumpD gives flush_IF_ID_o=1 for 1 cycle.
- FSM states are IDLE, FP_BUSY and HALT.
  - IDLE, FloatingE=1, FP_LATENCY>1: assert stall_IF_o, stall_IF_ID_o, stall_ID_EX_o and flush_EX_MEM_o this cycle. Load fp_cnt=FP_LATENCY-2 and go to FP_BUSY.
  - FP_BUSY, fp_cnt!=0: assert the same four outputs and decrement fp_cnt.
  - FP_BUSY, fp_cnt==0: no stall; go to IDLE. The FP op therefore sees exactly FP_LATENCY-1 stall cycles.
  - IDLE or FP_BUSY with StopE=1 and no FP stall active: go to HALT.
  - HALT: sticky until rst. halt_o=1, stall_IF_o=1, stall_IF_ID_o=1, flush_ID_EX_o=1; the pipeline drains with bubbles.
- Priority: HALT > FP stall > branch flush > jump flush > load-use.
- Invariant: stall_ID_EX_o and flush_ID_EX_o are never both 1, because ID/EX gives stall priority over flush.
- Reset mid-FP_BUSY or in HALT returns the block to IDLE on the next edge.

Decomposition:
- Shared package/include hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - State encodings ST_IDLE, ST_FP_BUSY, ST_HALT.
- One natural sub-module: forward_unit (pure comparator logic for one operand), instantiated twice for A and B.

Test Plan:
- RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3, rsE=3, rtE=3 -> forwardAE=forwardBE=2'b10; with RegWriteM=0 -> both 2'b01; with WriteRegM=0 and rsE=0 -> 2'b00.
- MemReadE=1, rtE=5, rsD=5 -> one cycle with stall_IF=stall_IF_ID=flush_ID_EX=1 and stall_ID_EX=0; next cycle with MemReadE=0 -> all 0.
- Same cycle: BranchE=1, branch_taken_i=1, MemReadE=1, rtE==rtD -> flush_IF_ID=flush_ID_EX=1, stall_IF=0.
- FP_LATENCY=4, FloatingE held 1 -> stalls plus flush_EX_MEM for exactly 3 cycles, then 0; the second consecutive FP op stalls again for 3 cycles.
- StopE=1 pulse -> halt_o=1 from the next cycle, held with StopE=0; rst=1 for one cycle -> halt_o=0; rst during FP_BUSY -> no stall after reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard unit.
//   FWD_*      : EX operand forwarding select encodings
//   FP_CNT_W   : width of the floating-point busy counter
//   hazState_e : hazard controller states
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file / ID/EX
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM (ALU) result

  // Wide enough for FP_LATENCY up to 15.
  localparam int FP_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FP_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } hazState_e;

endpackage

// File: rtl/hazard_unit_forward_unit.sv
// forward_unit: forwarding select for a single EX-stage source operand.
//   srcE                 : EX source register address
//   RegWriteM/WriteRegM  : MEM stage write enable / destination
//   RegWriteW/WriteRegW  : WB stage write enable / destination
//   forwardSel           : FWD_MEM, FWD_WB or FWD_RF (MEM wins over WB)
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_WIDTH  = 4,
  parameter bit R0_IS_ZERO = 1'b1
) (
  input  logic [REG_WIDTH-1:0] srcE,
  input  logic                 RegWriteM,
  input  logic [REG_WIDTH-1:0] WriteRegM,
  input  logic                 RegWriteW,
  input  logic [REG_WIDTH-1:0] WriteRegW,
  output logic [1:0]           forwardSel
);

  logic memHit;
  logic wbHit;

  // Register 0 is hardwired to zero, so a pending write to it must never
  // override the register-file value.
  assign memHit = RegWriteM && (WriteRegM == srcE) &&
                  (!R0_IS_ZERO || (WriteRegM != '0));
  assign wbHit  = RegWriteW && (WriteRegW == srcE) &&
                  (!R0_IS_ZERO || (WriteRegW != '0));

  always_comb begin
    forwardSel = FWD_RF;
    if (memHit) begin
      forwardSel = FWD_MEM;  // youngest result takes priority
    end else if (wbHit) begin
      forwardSel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the 16-bit 5-stage pipeline.
//   clk, rst                      : clock, synchronous active-high reset
//   rsD/rtD, rsE/rtE              : ID and EX register fields
//   MemReadE, BranchE, branch_taken_i, JumpD, FloatingE, StopE : control
//   RegWriteM/WriteRegM, RegWriteW/WriteRegW : later-stage writebacks
//   stall_*/flush_*               : pipeline register hold / clear
//   forwardAE_o/forwardBE_o       : EX operand forwarding selects
//   halt_o                        : processor halted (sticky until reset)
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_WIDTH  = 4,
  parameter int FP_LATENCY = 4,
  parameter bit R0_IS_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] rsD,
  input  logic [REG_WIDTH-1:0] rtD,
  input  logic [REG_WIDTH-1:0] rsE,
  input  logic [REG_WIDTH-1:0] rtE,
  input  logic                 MemReadE,
  input  logic                 BranchE,
  input  logic                 branch_taken_i,
  input  logic                 JumpD,
  input  logic                 FloatingE,
  input  logic                 StopE,
  input  logic                 RegWriteM,
  input  logic [REG_WIDTH-1:0] WriteRegM,
  input  logic                 RegWriteW,
  input  logic [REG_WIDTH-1:0] WriteRegW,
  output logic                 stall_IF_o,
  output logic                 stall_IF_ID_o,
  output logic                 flush_IF_ID_o,
  output logic                 stall_ID_EX_o,
  output logic                 flush_ID_EX_o,
  output logic                 flush_EX_MEM_o,
  output logic [1:0]           forwardAE_o,
  output logic [1:0]           forwardBE_o,
  output logic                 halt_o
);

  // A single-cycle FP op needs no stall at all.
  localparam bit FP_MULTI = (FP_LATENCY > 1);
  // The first stall cycle happens in IDLE, so the counter covers the rest.
  localparam logic [FP_CNT_W-1:0] FP_LOAD =
    FP_CNT_W'(FP_LATENCY > 1 ? FP_LATENCY - 2 : 0);

  hazState_e             stateReg,  stateNext;
  logic [FP_CNT_W-1:0]   fpCntReg,  fpCntNext;
  logic                  fpStall;
  logic                  lwStall;
  logic                  branchTaken;
  logic [1:0]            fwdA, fwdB;

  forward_unit #(.REG_WIDTH(REG_WIDTH), .R0_IS_ZERO(R0_IS_ZERO)) uFwdA (
    .srcE(rsE), .RegWriteM(RegWriteM), .WriteRegM(WriteRegM),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .forwardSel(fwdA)
  );

  forward_unit #(.REG_WIDTH(REG_WIDTH), .R0_IS_ZERO(R0_IS_ZERO)) uFwdB (
    .srcE(rtE), .RegWriteM(RegWriteM), .WriteRegM(WriteRegM),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .forwardSel(fwdB)
  );

  assign lwStall     = MemReadE && ((rtE == rsD) || (rtE == rtD));
  assign branchTaken = BranchE && branch_taken_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= ST_IDLE;
      fpCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      fpCntReg <= fpCntNext;
    end
  end

  // Next-state logic; fpStall is the FP hold request for the current cycle.
  always_comb begin
    stateNext = stateReg;
    fpCntNext = fpCntReg;
    fpStall   = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        if (FloatingE && FP_MULTI) begin
          fpStall   = 1'b1;
          stateNext = ST_FP_BUSY;
          fpCntNext = FP_LOAD;
        end else if (StopE) begin
          stateNext = ST_HALT;
        end
      end
      ST_FP_BUSY: begin
        if (fpCntReg != '0) begin
          fpStall   = 1'b1;
          fpCntNext = fpCntReg - 1'b1;
        end else if (StopE) begin
          stateNext = ST_HALT;
        end else begin
          // FP op leaves EX this cycle; a following FP op re-arms from IDLE.
          stateNext = ST_IDLE;
        end
      end
      ST_HALT: begin
        stateNext = ST_HALT;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Output arbitration: HALT > FP stall > branch > jump > load-use.
  // stall_ID_EX_o is only raised by the FP path, which never flushes ID/EX.
  always_comb begin
    stall_IF_o     = 1'b0;
    stall_IF_ID_o  = 1'b0;
    flush_IF_ID_o  = 1'b0;
    stall_ID_EX_o  = 1'b0;
    flush_ID_EX_o  = 1'b0;
    flush_EX_MEM_o = 1'b0;
    halt_o         = 1'b0;
    if (rst) begin
      // everything quiet while in reset
    end else if (stateReg == ST_HALT) begin
      halt_o        = 1'b1;
      stall_IF_o    = 1'b1;
      stall_IF_ID_o = 1'b1;
      flush_ID_EX_o = 1'b1;
    end else if (fpStall) begin
      stall_IF_o     = 1'b1;
      stall_IF_ID_o  = 1'b1;
      stall_ID_EX_o  = 1'b1;
      flush_EX_MEM_o = 1'b1;
    end else if (branchTaken) begin
      flush_IF_ID_o = 1'b1;
      flush_ID_EX_o = 1'b1;
    end else if (JumpD) begin
      flush_IF_ID_o = 1'b1;
    end else if (lwStall) begin
      stall_IF_o    = 1'b1;
      stall_IF_ID_o = 1'b1;
      flush_ID_EX_o = 1'b1;
    end
  end

  assign forwardAE_o = rst ? FWD_RF : fwdA;
  assign forwardBE_o = rst ? FWD_RF : fwdB;

endmodule
